// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer and its tag CAM.
package rob_pkg;

    localparam int ROB_DEPTH_DEF = 16;
    localparam int PHYS_W        = 6;
    localparam int ARCH_W        = 5;

    // Reserved tag: rename never hands it out, so a broadcast of it can never match.
    localparam logic [PHYS_W-1:0] INVALID_TAG = 6'b111111;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [PHYS_W-1:0] phys_rd;
        logic [PHYS_W-1:0] old_phys_rd;
        logic [ARCH_W-1:0] arch_rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_tag_match.sv
// Parallel tag compare over all buffer entries; only in-flight, not-yet-done
// entries are eligible to match a completion broadcast.
module rob_tag_match
    import rob_pkg::*;
#(
    parameter int N = ROB_DEPTH_DEF
) (
    input  logic [N-1:0]             valid,
    input  logic [N-1:0]             done,
    input  logic [N-1:0][PHYS_W-1:0] tags,
    input  logic                     query_valid,
    input  logic [PHYS_W-1:0]        query_tag,
    output logic [N-1:0]             match,
    output logic                     any_match
);

    // One-hot match vector (tags are unique among in-flight entries).
    always_comb begin
        match = '0;
        for (int i = 0; i < N; i++) begin
            match[i] = query_valid && (query_tag != INVALID_TAG) &&
                       valid[i] && !done[i] && (tags[i] == query_tag);
        end
        any_match = |match;
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, mark done by tag broadcast,
// retire from head one per cycle, returning the displaced physical register.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter  int ROB_DEPTH = ROB_DEPTH_DEF,
    localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_valid,
    input  logic [PHYS_W-1:0] alloc_phys_rd,
    input  logic [PHYS_W-1:0] alloc_old_phys_rd,
    input  logic [ARCH_W-1:0] alloc_arch_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              complete_valid,
    input  logic [PHYS_W-1:0] complete_phys_reg,
    output logic              complete_miss,
    output logic              retire_valid,
    output logic [PHYS_W-1:0] retire_phys_reg,
    output logic [PHYS_W-1:0] retire_new_phys,
    output logic [ARCH_W-1:0] retire_arch_rd,
    output logic [IDX_W:0]    count,
    output logic              empty,
    output logic              full
);

    rob_entry_t rob [ROB_DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;

    logic [ROB_DEPTH-1:0]             ent_valid;
    logic [ROB_DEPTH-1:0]             ent_done;
    logic [ROB_DEPTH-1:0][PHYS_W-1:0] ent_tag;
    logic [ROB_DEPTH-1:0]             tag_match;
    logic                             any_match;

    logic       alloc_fire;
    logic       bypass;
    logic       retire_fire;
    rob_entry_t head_entry;

    // Flatten entry state for the CAM.
    always_comb begin
        ent_valid = '0;
        ent_done  = '0;
        ent_tag   = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            ent_valid[i] = rob[i].valid;
            ent_done[i]  = rob[i].done;
            ent_tag[i]   = rob[i].phys_rd;
        end
    end

    rob_tag_match #(.N(ROB_DEPTH)) u_tag_match (
        .valid       (ent_valid),
        .done        (ent_done),
        .tags        (ent_tag),
        .query_valid (complete_valid),
        .query_tag   (complete_phys_reg),
        .match       (tag_match),
        .any_match   (any_match)
    );

    // Status, handshake and per-cycle fire decisions. Retire looks only at
    // registered head state, so a same-cycle completion waits one cycle.
    always_comb begin
        full        = (count == (IDX_W+1)'(ROB_DEPTH));
        empty       = (count == '0);
        alloc_ready = !full;
        alloc_idx   = tail;
        alloc_fire  = alloc_valid && alloc_ready;
        bypass      = alloc_fire && complete_valid &&
                      (complete_phys_reg != INVALID_TAG) &&
                      (alloc_phys_rd == complete_phys_reg);
        head_entry  = rob[head];
        retire_fire = head_entry.valid && head_entry.done;
    end

    // Entry array: retire clears head, CAM hit sets done, allocation writes tail.
    // Tail equals head only when empty or full, so alloc and retire never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (retire_fire && (IDX_W'(i) == head)) begin
                    rob[i].valid <= 1'b0;
                    rob[i].done  <= 1'b0;
                end
                if (tag_match[i]) begin
                    rob[i].done <= 1'b1;
                end
                if (alloc_fire && (IDX_W'(i) == tail)) begin
                    rob[i] <= '{valid: 1'b1, done: bypass, phys_rd: alloc_phys_rd,
                                old_phys_rd: alloc_old_phys_rd, arch_rd: alloc_arch_rd};
                end
            end
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + IDX_W'(1);
            end
            if (retire_fire) begin
                head <= head + IDX_W'(1);
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + (IDX_W+1)'(1);
                2'b01:   count <= count - (IDX_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered retire and miss pulses; retire fields hold between retirements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_valid    <= 1'b0;
            retire_phys_reg <= '0;
            retire_new_phys <= '0;
            retire_arch_rd  <= '0;
            complete_miss   <= 1'b0;
        end else begin
            retire_valid  <= retire_fire;
            complete_miss <= complete_valid && !any_match && !bypass;
            if (retire_fire) begin
                retire_phys_reg <= head_entry.old_phys_rd;
                retire_new_phys <= head_entry.phys_rd;
                retire_arch_rd  <= head_entry.arch_rd;
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer sitting directly downstream of the rename stage. Each renamed instruction is allocated an entry holding its new physical destination, the displaced physical register and the architectural destination. Entries are marked complete by physical-tag broadcast from the execution units and retire strictly in program order, one per cycle. Retirement returns the displaced physical register to rename's free list.

## Interface
- ROB_DEPTH, 16, number of entries; power of two, at least 4
- PHYS_W, 6, physical register tag width
- ARCH_W, 5, architectural register index width
- IDX_W, $clog2(ROB_DEPTH), entry index width (derived)

- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- alloc_valid  in  1  allocate one entry this cycle
- alloc_phys_rd  in  PHYS_W  new physical destination (rename phys_rd)
- alloc_old_phys_rd  in  PHYS_W  displaced mapping (rename old_phys_rd)
- alloc_arch_rd  in  ARCH_W  architectural destination
- alloc_ready  out  1  not full; combinational from count
- alloc_idx  out  IDX_W  entry index that an allocation this cycle takes (tail pointer)
- complete_valid  in  1  execution-unit completion broadcast
- complete_phys_reg  in  PHYS_W  physical tag that completed
- complete_miss  out  1  registered one-cycle pulse: the broadcast matched no eligible entry
- retire_valid  out  1  registered one-cycle pulse per retired entry
- retire_phys_reg  out  PHYS_W  old_phys_rd of the retired entry, to be freed
- retire_new_phys  out  PHYS_W  phys_rd of the retired entry
- retire_arch_rd  out  ARCH_W  arch_rd of the retired entry
- count  out  IDX_W+1  occupied entries
- empty, full  out  1  count==0, count==ROB_DEPTH

## Operation
- Per-entry state: valid, done, phys_rd, old_phys_rd, arch_rd. Circular buffer with head (oldest) and tail pointers, each IDX_W bits. Pointers wrap modulo ROB_DEPTH. count is tracked separately to disambiguate full from empty.
- Allocate: when alloc_valid && alloc_ready, write the entry at tail with valid=1 and done=0, then tail+1. When alloc_valid && !alloc_ready, the request is dropped and no state changes. The upstream stage must gate alloc_valid on alloc_ready.
- Complete: an eligible entry is valid && !done && phys_rd==complete_phys_reg. All entries are compared in parallel (CAM). Tags are unique among in-flight entries, so at most one entry matches, and it gets done=1.
- If no eligible entry matches, complete_miss pulses the next cycle and no state changes.
- If an allocation occurs in the same cycle with alloc_phys_rd==complete_phys_reg, the new entry is written with done=1. This bypass counts as a match: no miss.
- Retire: when the head entry is valid && done, clear it, advance head by 1, and drive retire_valid=1 with that entry's fields on the next cycle. At most one retirement per cycle.
- Simultaneous alloc+retire: count is unchanged and both pointers advance.
- Allocation while full is never accepted, even if a retire happens in the same cycle. alloc_ready depends only on count.
- A completion arriving in the same cycle the head is checked does not make the head eligible until the following cycle.
- No flush or mispredict recovery.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - head=tail=0, count=0, every valid and done bit = 0
  - retire_valid=0, retire_phys_reg=retire_new_phys=0, retire_arch_rd=0
  - complete_miss=0, alloc_ready=1, empty=1, full=0, alloc_idx=0
- Allocate to earliest retire: alloc at edge N, complete at edge N+1, head eligible from edge N+2, retire_valid high after edge N+2. Back-to-back completed entries retire on consecutive cycles.
- Allocate with bypassed completion at edge N: retire_valid high after edge N+1 if the entry is the head.
- retire_* fields hold their last value while retire_valid=0. Consumers qualify them with retire_valid.
- count, empty and full update at the same edge as the pointer moves.

## Structure
- Shared package rob_pkg holds:
  - the PHYS_W, ARCH_W and ROB_DEPTH defaults
  - the rob_entry_t struct (valid, done, phys_rd, old_phys_rd, arch_rd)
  - the invalid-tag constant 6'b111111, which is never allocated and never matches a completion
- One natural sub-module: rob_tag_match. It is a combinational CAM that returns a one-hot match vector over eligible entries plus an any_match bit. It is used for completion marking and for the miss detection.

## Test plan
- Reset, then alloc phys 32/33/34 (old 1/2/3, arch 1/2/3), then complete tags 34, 32, 33 out of order -> retire_valid on three consecutive cycles with retire_phys_reg=1, 2, 3 in order; count returns to 0; empty=1.
- Allocate 16 entries with no completions -> full=1, alloc_ready=0. Assert a 17th alloc -> dropped, count stays 16. Complete the head's tag -> one retire, then alloc_ready=1.
- Fill and drain the buffer 3 times so the pointers wrap past index 15 -> retirement order and fields stay correct; alloc_idx sequence is 0..15,0..
- Same-cycle alloc of tag 40 into an empty buffer with complete_phys_reg=40 -> no complete_miss; retire_valid 1 cycle later with retire_new_phys=40.
- Complete tag 50 with no entry holding it, then repeat tag 32 after it is already done -> complete_miss pulses once per broadcast; count unchanged.
- Assert reset_n low mid-stream while 5 entries are pending and one retire is in flight -> all outputs reach their reset values immediately. After release, an alloc lands at alloc_idx=0.
